// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - region codes, device indices and state type for the I/O bus controller
package io_map_pkg;

    localparam logic [3:0] REGION_DMEM = 4'h0;
    localparam logic [3:0] REGION_VGA  = 4'h1;
    localparam logic [3:0] REGION_SEG  = 4'h3;
    localparam logic [3:0] REGION_BTN  = 4'h4;
    localparam logic [3:0] REGION_SD   = 4'h8;

    localparam int NUM_DEV  = 5;
    localparam int DEV_DMEM = 0;
    localparam int DEV_VGA  = 1;
    localparam int DEV_SEG  = 2;
    localparam int DEV_BTN  = 3;
    localparam int DEV_SD   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } bus_state_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - region code to one-hot device select
module io_addr_decode
    import io_map_pkg::*;
(
    input  logic [3:0]         region,
    output logic [NUM_DEV-1:0] sel,
    output logic               mapped
);

    always_comb begin
        sel = '0;
        case (region)
            REGION_DMEM: sel[DEV_DMEM] = 1'b1;
            REGION_VGA:  sel[DEV_VGA]  = 1'b1;
            REGION_SEG:  sel[DEV_SEG]  = 1'b1;
            REGION_BTN:  sel[DEV_BTN]  = 1'b1;
            REGION_SD:   sel[DEV_SD]   = 1'b1;
            default:     sel = '0;
        endcase
        mapped = |sel;
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - single-outstanding CPU I/O access sequencer with SD ready/timeout
module io_bus_ctrl
    import io_map_pkg::*;
#(
    parameter int unsigned FAST_LAT   = 1,
    parameter int unsigned SD_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_stall,
    output logic               cpu_done,
    output logic [31:0]        cpu_rdata,
    output logic               bus_err,
    output logic [NUM_DEV-1:0] dev_sel,
    output logic               dev_we,
    output logic [31:0]        dev_addr,
    output logic [31:0]        dev_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic [31:0]        vga_rdata,
    input  logic [31:0]        seg_rdata,
    input  logic [31:0]        btn_rdata,
    input  logic [31:0]        sd_rdata,
    input  logic               sd_ready
);

    localparam logic [15:0] FAST_LAST = 16'(FAST_LAT - 1);
    localparam logic [15:0] SD_LAST   = 16'(SD_TIMEOUT - 1);

    bus_state_t         state;
    logic [15:0]        cnt;
    logic [3:0]         dec_region;
    logic [NUM_DEV-1:0] dec_sel;
    logic               dec_mapped;
    logic [31:0]        rd_mux;
    logic               access_ok;
    logic               access_timeout;

    // Decoder sits on the input of the address latch, so the select it
    // produces is exactly the one registered alongside dev_addr.
    assign dec_region = (state == ST_IDLE) ? cpu_addr[31:28] : dev_addr[31:28];

    io_addr_decode u_decode (
        .region (dec_region),
        .sel    (dec_sel),
        .mapped (dec_mapped)
    );

    always_comb begin
        rd_mux = ({32{dev_sel[DEV_DMEM]}} & dmem_rdata)
               | ({32{dev_sel[DEV_VGA]}}  & vga_rdata)
               | ({32{dev_sel[DEV_SEG]}}  & seg_rdata)
               | ({32{dev_sel[DEV_BTN]}}  & btn_rdata)
               | ({32{dev_sel[DEV_SD]}}   & sd_rdata);
    end

    // Ready wins over timeout when both land in the same cycle.
    always_comb begin
        access_ok      = 1'b0;
        access_timeout = 1'b0;
        if (state == ST_ACCESS) begin
            if (dev_sel[DEV_SD]) begin
                access_ok      = sd_ready;
                access_timeout = !sd_ready && (cnt == SD_LAST);
            end else begin
                access_ok      = (cnt == FAST_LAST);
            end
        end
    end

    assign cpu_stall = ((state == ST_IDLE) && cpu_req) || (state == ST_ACCESS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            cpu_done  <= 1'b0;
            bus_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        dev_addr  <= cpu_addr;
                        dev_wdata <= cpu_wdata;
                        cnt       <= '0;
                        if (dec_mapped) begin
                            state   <= ST_ACCESS;
                            dev_sel <= dec_sel;
                            dev_we  <= cpu_we;
                        end else begin
                            state     <= ST_ERR;
                            cpu_done  <= 1'b1;
                            bus_err   <= 1'b1;
                            cpu_rdata <= ERR_RDATA;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (access_ok) begin
                        state    <= ST_DONE;
                        cpu_done <= 1'b1;
                        if (!dev_we) begin
                            cpu_rdata <= rd_mux;
                        end
                        dev_sel <= '0;
                        dev_we  <= 1'b0;
                    end else if (access_timeout) begin
                        state     <= ST_ERR;
                        cpu_done  <= 1'b1;
                        bus_err   <= 1'b1;
                        cpu_rdata <= ERR_RDATA;
                        dev_sel   <= '0;
                        dev_we    <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - transaction-level model and directed tests for io_bus_ctrl
module tb_io_bus_ctrl;

    localparam int FAST_LAT   = 1;
    localparam int SD_TIMEOUT = 8;
    localparam int NEVER      = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        bus_err;
    logic [4:0]  dev_sel;
    logic        dev_we;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [31:0] dmem_rdata, vga_rdata, seg_rdata, btn_rdata, sd_rdata;
    logic        sd_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sd_ready_cyc = NEVER;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign sd_ready = (cyc >= sd_ready_cyc);

    io_bus_ctrl #(.FAST_LAT(FAST_LAT), .SD_TIMEOUT(SD_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .bus_err(bus_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dmem_rdata(dmem_rdata), .vga_rdata(vga_rdata), .seg_rdata(seg_rdata),
        .btn_rdata(btn_rdata), .sd_rdata(sd_rdata), .sd_ready(sd_ready)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [4:0] region_onehot(input logic [3:0] r);
        case (r)
            4'h0: return 5'b00001;
            4'h1: return 5'b00010;
            4'h3: return 5'b00100;
            4'h4: return 5'b01000;
            4'h8: return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // Model: one outstanding transaction described by its accept cycle t0,
    // number of device-select cycles, and outcome; outputs follow from that.
    bit          have = 1'b0;
    int          t0, dur, acc_cnt = 0;
    bit          is_err, t_we;
    logic [4:0]  t_sel;
    logic [31:0] t_cap;
    logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
    bit          m_acc, m_fin, m_idle;
    int          j;

    always @(negedge clk) begin
        m_acc  = have && (cyc > t0) && (cyc <= t0 + dur);
        m_fin  = have && (cyc == t0 + dur + 1);
        m_idle = !m_acc && !m_fin;
        if (m_fin) m_rdata = is_err ? 32'h0 : (t_we ? m_rdata : t_cap);
        if (chk_en) begin
            chk("dev_sel",   32'(dev_sel),   m_acc ? 32'(t_sel) : 32'h0);
            chk("dev_we",    32'(dev_we),    32'(m_acc && t_we));
            chk("cpu_done",  32'(cpu_done),  32'(m_fin));
            chk("bus_err",   32'(bus_err),   32'(m_fin && is_err));
            chk("cpu_stall", 32'(cpu_stall), 32'(m_acc || (m_idle && cpu_req)));
            chk("cpu_rdata", cpu_rdata, m_rdata);
            chk("dev_addr",  dev_addr,  m_addr);
            chk("dev_wdata", dev_wdata, m_wdata);
        end
        if (m_fin) have = 1'b0;
        if (!rst_n) begin
            have = 1'b0; m_rdata = '0; m_addr = '0; m_wdata = '0;
        end else if (m_idle && cpu_req) begin
            t_sel  = region_onehot(cpu_addr[31:28]);
            t_we   = cpu_we;
            t0     = cyc;
            m_addr = cpu_addr;
            m_wdata = cpu_wdata;
            case (t_sel)
                5'b00001: t_cap = dmem_rdata;
                5'b00010: t_cap = vga_rdata;
                5'b00100: t_cap = seg_rdata;
                5'b01000: t_cap = btn_rdata;
                default:  t_cap = sd_rdata;
            endcase
            if (t_sel == 5'b0) begin
                dur = 0; is_err = 1'b1;
            end else if (t_sel != 5'b10000) begin
                dur = FAST_LAT; is_err = 1'b0;
            end else begin
                j = (sd_ready_cyc - cyc < 1) ? 1 : sd_ready_cyc - cyc;
                if (j > SD_TIMEOUT) begin
                    dur = SD_TIMEOUT; is_err = 1'b1;
                end else begin
                    dur = j; is_err = 1'b0;
                end
            end
            have = 1'b1;
            acc_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd);
        int ts;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        ts = cyc; lat = -1; err = 1'bx; rd = 'x;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cpu_done) begin
                lat = cyc - ts; err = bus_err; rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        if (lat < 0) chk("xact_bound", 32'(lat), 32'h0);
        step();
    endtask

    int          lat;
    logic        err;
    logic [31:0] rd;

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dmem_rdata = 32'h1234_5678; vga_rdata = 32'h0000_0B0B; seg_rdata = 32'h5E65_E6E6;
        btn_rdata = 32'h0000_000F; sd_rdata = 32'hA5A5_A5A5;
        step(); step();
        rst_n = 1'b1; chk_en = 1'b1;
        chk("rst_dev_sel", 32'(dev_sel), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_dev_addr", dev_addr, 32'h0);
        step();

        xact(1'b0, 32'h0000_0010, 32'h0, lat, err, rd);
        chk("dmem_lat", 32'(lat), 32'd2);
        chk("dmem_rdata", rd, 32'h1234_5678);

        xact(1'b1, 32'h3000_0000, 32'hCAFE_0001, lat, err, rd);
        chk("seg_store_lat", 32'(lat), 32'd2);
        chk("seg_store_rdata_kept", rd, 32'h1234_5678);
        chk("seg_wdata", dev_wdata, 32'hCAFE_0001);

        xact(1'b0, 32'h1000_0004, 32'h0, lat, err, rd);
        chk("vga_rdata", rd, 32'h0000_0B0B);
        xact(1'b0, 32'h4000_0000, 32'h0, lat, err, rd);
        chk("btn_rdata", rd, 32'h0000_000F);

        sd_ready_cyc = cyc + 5;
        xact(1'b0, 32'h8000_0000, 32'h0, lat, err, rd);
        chk("sd5_lat", 32'(lat), 32'd6);
        chk("sd5_err", 32'(err), 32'd0);
        chk("sd5_rdata", rd, 32'hA5A5_A5A5);

        xact(1'b0, 32'h0000_0010, 32'h0, lat, err, rd);
        sd_ready_cyc = NEVER;
        xact(1'b0, 32'h8000_0040, 32'h0, lat, err, rd);
        chk("sdto_lat", 32'(lat), 32'd9);
        chk("sdto_err", 32'(err), 32'd1);
        chk("sdto_rdata", rd, 32'h0);

        sd_ready_cyc = cyc + 8;
        xact(1'b0, 32'h8000_0080, 32'h0, lat, err, rd);
        chk("sd8_lat", 32'(lat), 32'd9);
        chk("sd8_err", 32'(err), 32'd0);
        chk("sd8_rdata", rd, 32'hA5A5_A5A5);

        sd_ready_cyc = cyc;
        xact(1'b1, 32'h8000_0004, 32'h0000_5D5D, lat, err, rd);
        chk("sd_store_lat", 32'(lat), 32'd2);
        chk("sd_store_rdata_kept", rd, 32'hA5A5_A5A5);

        // reset while waiting on SD
        sd_ready_cyc = NEVER;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0100;
        step(); step(); step();
        chk("pre_rst_sd_sel", 32'(dev_sel), 32'h10);
        rst_n = 1'b0; cpu_req = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_sel", 32'(dev_sel), 32'h0);
        chk("rst_mid_done", 32'(cpu_done), 32'h0);
        chk("rst_mid_rdata", cpu_rdata, 32'h0);
        chk("rst_mid_addr", dev_addr, 32'h0);
        step(); step();

        // unmapped followed by a request held through the ERR cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000_0000;
        step();
        chk("unmap_err", 32'(bus_err), 32'h1);
        chk("unmap_sel", 32'(dev_sel), 32'h0);
        cpu_addr = 32'h0000_0020;
        step();
        chk("b2b_idle_done", 32'(cpu_done), 32'h0);
        chk("b2b_idle_stall", 32'(cpu_stall), 32'h1);
        step();
        chk("b2b_sel", 32'(dev_sel), 32'h01);
        chk("b2b_addr", dev_addr, 32'h0000_0020);
        step();
        chk("b2b_done", 32'(cpu_done), 32'h1);
        chk("b2b_rdata", cpu_rdata, 32'h1234_5678);
        cpu_req = 1'b0;
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Sequencing controller for the CPU's memory-mapped I/O bus. Accepts one CPU load/store at a time, decodes `addr[31:28]` into a one-hot device select, and holds the select for the device's access time. It waits on a ready handshake for the slow SD interface, with a timeout, and returns registered read data with a completion pulse. It sits between the CPU data port and the data memory, VGA, 7-segment, button and SD blocks, and replaces the free-running combinational read mux with a stall-aware, latched path.

## Interface
- `FAST_LAT`, 1: cycles `dev_sel` is held for dmem/vga/seg/button; range 1–15.
- `SD_TIMEOUT`, 1023: maximum `ACCESS` cycles waiting for `sd_ready` before bus error; range 1–65535.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cpu_req` in 1: access request; the CPU holds it high while `cpu_stall` is high.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address; bits [31:28] select the region.
- `cpu_wdata` in 32: store data.
- `cpu_stall` out 1: CPU must hold the pipeline.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: registered load data; valid while `cpu_done` is high and held until the next completion.
- `bus_err` out 1: one-cycle pulse on unmapped address or SD timeout.
- `dev_sel` out 5: one-hot device select. Bit 0 = dmem, 1 = vga, 2 = seg, 3 = button, 4 = sd.
- `dev_we` out 1: write strobe; valid only while `dev_sel` is nonzero.
- `dev_addr` out 32: latched address.
- `dev_wdata` out 32: latched store data.
- `dmem_rdata`, `vga_rdata`, `seg_rdata`, `btn_rdata`, `sd_rdata` in 32 each: device read data.
- `sd_ready` in 1: SD transfer complete; sampled only while `dev_sel[4]` is high.

## Operation
- Region map for `addr[31:28]`: 0x0 dmem, 0x1 vga, 0x3 seg, 0x4 button, 0x8 sd. All other codes are unmapped.
- States: `IDLE`, `ACCESS`, `DONE`, `ERR`.
- `IDLE`:
  - `cpu_req` is sampled only in this state.
  - On request: latch addr, we and wdata; load `cnt` = 0.
  - Mapped address → `ACCESS`; unmapped → `ERR`.
- `ACCESS`:
  - `dev_sel` drives the decoded bit; `dev_we` = latched we.
  - Fast device: `cnt` increments each cycle. When `cnt == FAST_LAT-1`, capture the device rdata (loads) and go to `DONE`.
  - SD: if `sd_ready` is high, capture `sd_rdata` (loads) and go to `DONE`.
  - SD: otherwise, if `cnt == SD_TIMEOUT-1`, go to `ERR`; else increment `cnt`.
  - `sd_ready` has priority over timeout when both occur in the same cycle.
- `DONE`: `cpu_done` = 1, then → `IDLE`.
  - Stores leave `cpu_rdata` unchanged.
- `ERR`: `cpu_done` = 1, `bus_err` = 1, `cpu_rdata` loaded with 0, then → `IDLE`.
  - No device is selected for an unmapped access. A timed-out store is dropped.
- `cpu_stall` = (`IDLE` and `cpu_req`) or `ACCESS`. It is low in `DONE` and `ERR`.
- `cnt` is 16 bits and never wraps: it is compared before incrementing.
- Reset in any state:
  - Next cycle the controller is in `IDLE`.
  - `dev_sel` = 0, `dev_we` = 0, `cpu_done` = 0, `bus_err` = 0.
  - `cpu_rdata` = 0, `dev_addr` = 0, `dev_wdata` = 0, `cnt` = 0.
  - An in-flight access is abandoned, with no done pulse.

## Timing
- Fast access with `FAST_LAT` = 1:
  - Cycle 0: `IDLE`, request latched, stall high.
  - Cycle 1: `ACCESS`, `dev_sel` high.
  - Cycle 2: `DONE`.
  - Request-to-done latency is 1 + `FAST_LAT` cycles.
- SD access: done pulses 1 cycle after the first `ACCESS` cycle with `sd_ready` high. Worst case is 1 + `SD_TIMEOUT` cycles to `ERR`.
- Unmapped access: `ERR` in cycle 1.
- Back-to-back requests: a request held high in the `DONE`/`ERR` cycle is not sampled. It is accepted in the following `IDLE` cycle. Minimum spacing is 2 + `FAST_LAT` cycles.
- Only the latched registers drive `dev_*`; they do not follow `cpu_addr` changes during `ACCESS`.

## Structure
- Package `io_map_pkg` holds:
  - region code constants (4-bit);
  - `dev_sel` bit indices and `NUM_DEV` = 5;
  - the state enum typedef;
  - `ERR_RDATA` = 32'h0.
- Sub-module `io_addr_decode`: combinational; takes `addr[31:28]` and produces one-hot `sel[4:0]` plus `mapped`. It is instantiated once, on the latched address path.
- The remaining logic (FSM, counter, data capture) stays in `io_bus_ctrl`.

## Test plan
- Reset mid-SD-wait:
  - Stimulus: hold `rst_n` = 0 for one cycle while in `ACCESS` with sd.
  - Response: `IDLE` next cycle, all outputs 0, no `cpu_done`.
- Load from dmem:
  - Stimulus: load, addr 0x0000_0010, `dmem_rdata` = 0x1234_5678, `FAST_LAT` = 1.
  - Response: `dev_sel` = 5'b00001 for exactly 1 cycle; `cpu_done` at cycle 2 with `cpu_rdata` = 0x1234_5678; stall high cycles 0–1.
- Store to seg:
  - Stimulus: store, addr 0x3000_0000, wdata 0xCAFE_0001.
  - Response: `dev_sel` = 5'b00100, `dev_we` = 1, `dev_wdata` = 0xCAFE_0001 for 1 cycle; `cpu_rdata` unchanged.
- SD load with delayed ready:
  - Stimulus: load, addr 0x8000_0000; `sd_ready` rises on the 5th `ACCESS` cycle; `sd_rdata` = 0xA5A5_A5A5.
  - Response: done 1 cycle later with 0xA5A5_A5A5, no `bus_err`.
- SD timeout:
  - Stimulus: `SD_TIMEOUT` = 8, `sd_ready` held 0.
  - Response: 8 `ACCESS` cycles, then `ERR` with `bus_err` = 1, `cpu_done` = 1, `cpu_rdata` = 0.
  - Repeat with ready on exactly the 8th cycle: `DONE` with no error.
- Unmapped and back-to-back:
  - Stimulus: request to addr 0x2000_0000.
  - Response: `dev_sel` stays 0; `ERR` at cycle 1.
  - Stimulus: a dmem request held through that `ERR` cycle.
  - Response: it is accepted in the following `IDLE` cycle.
